traffic_light_monitor: RTL and testbench

- Passive checker on the light-code outputs of the highway/country traffic controller.
- Samples the controller's sensor input X and its light outputs H and C every clock.
- Checks the light sequence against the safety and protocol rules below; raises sticky error flags and keeps event counters.
- Sits beside the controller in simulation and FPGA builds; drives nothing back into the controller.

---
 rtl/traffic_light_monitor.sv | 119 +++++++++++
 tb/tb_traffic_light_monitor.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive safety/protocol checker for the highway/country traffic controller.
// Samples X/H/C every clock and raises sticky error flags plus event counters.
module traffic_light_monitor #(
    parameter int unsigned YELLOW_MIN = 3,
    parameter int unsigned MAX_WAIT   = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             X,
    input  logic [1:0]       H,
    input  logic [1:0]       C,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic             err_spurious,
    output logic             err_starve,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] country_phases
);

    localparam int unsigned YW = $clog2(YELLOW_MIN + 1);
    localparam int unsigned WW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] BAD = 2'd3;

    logic [1:0]    prev_h, prev_c;
    logic [YW-1:0] ydw_h, ydw_c;
    logic [WW-1:0] wait_cnt;
    logic          x_seen;

    logic [1:0]       prev_h_nxt, prev_c_nxt;
    logic [YW-1:0]    ydw_h_nxt, ydw_c_nxt;
    logic [WW-1:0]    wait_nxt;
    logic             x_seen_nxt;
    logic             v_conflict, v_sequence, v_timing, v_spurious, v_starve, v_any;
    logic [CNT_W-1:0] err_count_nxt, phases_nxt;

    // An invalid previous code carries no history, so the recovery step is not judged.
    function automatic logic step_ok(input logic [1:0] p, input logic [1:0] c);
        return (p == c) || (p == BAD) ||
               (p == RED && c == GRN) || (p == GRN && c == YEL) || (p == YEL && c == RED);
    endfunction

    // Violation detection and next-state for all tracking registers
    always_comb begin
        v_conflict = (H != RED) && (C != RED);
        v_sequence = !step_ok(prev_h, H) || !step_ok(prev_c, C) || (H == BAD) || (C == BAD);
        v_timing   = (prev_h == YEL && H == RED && ydw_h < YW'(YELLOW_MIN)) ||
                     (prev_c == YEL && C == RED && ydw_c < YW'(YELLOW_MIN));
        v_spurious = (prev_c == RED) && (C == GRN) && !x_seen && !X;
        v_starve   = X && (C == RED) && (wait_cnt == WW'(MAX_WAIT - 1));
        v_any      = v_conflict | v_sequence | v_timing | v_spurious | v_starve;

        prev_h_nxt = H;
        prev_c_nxt = C;

        ydw_h_nxt = '0;
        if (H == YEL)
            ydw_h_nxt = (ydw_h == YW'(YELLOW_MIN)) ? ydw_h : ydw_h + YW'(1);
        ydw_c_nxt = '0;
        if (C == YEL)
            ydw_c_nxt = (ydw_c == YW'(YELLOW_MIN)) ? ydw_c : ydw_c + YW'(1);

        wait_nxt = '0;
        if (X && C == RED)
            wait_nxt = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);

        // A car seen in the very sample where highway green starts still counts.
        x_seen_nxt = X | (x_seen & !(prev_h == RED && H == GRN));

        err_count_nxt = err_count;
        if (v_any && err_count != '1)
            err_count_nxt = err_count + CNT_W'(1);

        phases_nxt = country_phases;
        if (prev_c == YEL && C == RED)
            phases_nxt = country_phases + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            prev_h         <= GRN;
            prev_c         <= RED;
            ydw_h          <= '0;
            ydw_c          <= '0;
            wait_cnt       <= '0;
            x_seen         <= 1'b0;
            err_conflict   <= 1'b0;
            err_sequence   <= 1'b0;
            err_timing     <= 1'b0;
            err_spurious   <= 1'b0;
            err_starve     <= 1'b0;
            err_pulse      <= 1'b0;
            err_count      <= '0;
            country_phases <= '0;
        end else begin
            prev_h         <= prev_h_nxt;
            prev_c         <= prev_c_nxt;
            ydw_h          <= ydw_h_nxt;
            ydw_c          <= ydw_c_nxt;
            wait_cnt       <= wait_nxt;
            x_seen         <= x_seen_nxt;
            err_conflict   <= err_conflict | v_conflict;
            err_sequence   <= err_sequence | v_sequence;
            err_timing     <= err_timing   | v_timing;
            err_spurious   <= err_spurious | v_spurious;
            err_starve     <= err_starve   | v_starve;
            err_pulse      <= v_any;
            err_count      <= err_count_nxt;
            country_phases <= phases_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Table-driven bench for traffic_light_monitor with a scoreboard queue of
// expected outputs, plus saturation and wrap sequences.
module tb_traffic_light_monitor;

    logic       clock, clear, X;
    logic [1:0] H, C;
    logic       err_conflict, err_sequence, err_timing, err_spurious, err_starve, err_pulse;
    logic [7:0] err_count, country_phases;

    traffic_light_monitor #(.YELLOW_MIN(3), .MAX_WAIT(16), .CNT_W(8)) dut (
        .clock(clock), .clear(clear), .X(X), .H(H), .C(C),
        .err_conflict(err_conflict), .err_sequence(err_sequence),
        .err_timing(err_timing), .err_spurious(err_spurious),
        .err_starve(err_starve), .err_pulse(err_pulse),
        .err_count(err_count), .country_phases(country_phases)
    );

    // flags = {conflict, sequence, timing, spurious, starve}
    typedef struct packed {
        logic [4:0] flags;
        logic       pulse;
        logic [7:0] cnt;
        logic [7:0] ph;
    } out_t;

    typedef struct {
        logic       clr;
        logic       x;
        logic [1:0] h;
        logic [1:0] c;
        int         n;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    out_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got checks=%0d required completion", checks);
        $fatal(1, "timeout");
    end

    function automatic out_t mk_out(input logic [4:0] f, input logic p, input int cnt, input int ph);
        out_t o;
        o.flags = f;
        o.pulse = p;
        o.cnt   = 8'(cnt);
        o.ph    = 8'(ph);
        return o;
    endfunction

    function automatic vec_t mk(input logic clr, input logic x, input logic [1:0] h,
                                input logic [1:0] c, input int n, input logic [4:0] f,
                                input logic p, input int cnt, input int ph);
        vec_t v;
        v.clr = clr; v.x = x; v.h = h; v.c = c; v.n = n;
        v.exp = mk_out(f, p, cnt, ph);
        return v;
    endfunction

    task automatic compare(input string tag);
        out_t e, got;
        e   = exp_q.pop_front();
        got = {err_conflict, err_sequence, err_timing, err_spurious, err_starve,
               err_pulse, err_count, country_phases};
        checks++;
        if (got == e) passed++;
        else $display("FAIL %s: got flags=%b pulse=%b cnt=%0d ph=%0d, required flags=%b pulse=%b cnt=%0d ph=%0d",
                      tag, got.flags, got.pulse, got.cnt, got.ph, e.flags, e.pulse, e.cnt, e.ph);
    endtask

    // Drive one sample, queue its expectation, compare after the edge that samples it
    task automatic step(input string tag, input logic clr_i, input logic x_i,
                        input logic [1:0] h_i, input logic [1:0] c_i, input out_t e);
        clear = clr_i; X = x_i; H = h_i; C = c_i;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        compare(tag);
    endtask

    initial begin
        clear = 1'b1; X = 1'b0; H = 2'd2; C = 2'd0;

        // reset hold and idle
        tbl.push_back(mk(1, 0, 2, 0,  2, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 20, 5'b00000, 0, 0, 0));
        // legal phase
        tbl.push_back(mk(0, 0, 2, 0,  2, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  3, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  3, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 2, 0,  1, 5'b00000, 0, 0, 1));
        // conflict then skipped yellow
        tbl.push_back(mk(1, 0, 2, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 2,  1, 5'b10000, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 2,  1, 5'b11000, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 2,  3, 5'b11000, 0, 2, 0));
        // short yellow then invalid code
        tbl.push_back(mk(1, 0, 2, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  2, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00100, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 3,  1, 5'b01100, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0,  2, 5'b01100, 0, 2, 0));
        // spurious country green, then starvation
        tbl.push_back(mk(1, 0, 2, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  3, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2,  1, 5'b00010, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1,  3, 5'b00010, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00010, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0, 15, 5'b00010, 0, 1, 1));
        tbl.push_back(mk(0, 1, 0, 0,  1, 5'b00011, 1, 2, 1));
        tbl.push_back(mk(0, 1, 0, 0,  3, 5'b00011, 0, 2, 1));
        // reset mid-yellow with err_timing set, then resume from GREEN
        tbl.push_back(mk(1, 0, 2, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00100, 1, 1, 0));
        tbl.push_back(mk(0, 0, 2, 0,  1, 5'b00100, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0,  1, 5'b00100, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0,  1, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0,  3, 5'b00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 5'b00000, 0, 0, 0));

        foreach (tbl[i])
            for (int r = 0; r < tbl[i].n; r++)
                step($sformatf("vec%0d.%0d", i, r), tbl[i].clr, tbl[i].x, tbl[i].h, tbl[i].c, tbl[i].exp);

        // err_count saturation: invalid code with conflict every cycle
        step("sat_rst", 1, 0, 2, 0, mk_out(5'b00000, 0, 0, 0));
        for (int k = 1; k <= 260; k++)
            step($sformatf("sat%0d", k), 0, 0, 2, 3, mk_out(5'b11000, 1, (k > 255) ? 255 : k, 0));

        // country_phases wrap over 257 full country phases
        step("wrap_rst", 1, 0, 2, 0, mk_out(5'b00000, 0, 0, 0));
        step("wrap_hred", 0, 1, 0, 0, mk_out(5'b01000, 1, 1, 0));
        for (int i = 1; i <= 257; i++) begin
            step($sformatf("wrap%0d_g", i), 0, 1, 0, 2, mk_out(5'b01000, 0, 1, i - 1));
            for (int y = 0; y < 3; y++)
                step($sformatf("wrap%0d_y%0d", i, y), 0, 1, 0, 1, mk_out(5'b01000, 0, 1, i - 1));
            step($sformatf("wrap%0d_r", i), 0, 1, 0, 0, mk_out(5'b01000, 0, 1, i));
        end

        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
